uart_tx_word: RTL and testbench

Parametrised word-serialising UART transmitter. It replaces the fixed 32-bit / 9600-baud transmit path.
- Accepts WORD_W-bit words through a write strobe into an internal word FIFO.
- Splits each word into DATA_BITS-wide characters and transmits them back-to-back on tx.
- Stop-bit count, byte order and bit period are configurable.
- Sits between the velocity-curve datapath (word producer) and the board TX pin, with full/level back-pressure and a sticky overflow flag.

---
 rtl/uart_tx_word.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_word.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_word.sv
// uart_tx_word: word FIFO feeding a back-to-back UART character serialiser.
// Define UART_PARITY_EN to append a parity bit (sense set by PARITY_ODD) to every character.
module uart_tx_word #(
   parameter int WORD_W         = 32,
   parameter int DATA_BITS      = 8,
   parameter int BIT_CYCLES     = 1250,
   parameter int FIFO_ADDR      = 4,
   parameter int STOP_BITS      = 1,
   parameter int MSB_BYTE_FIRST = 0,
   parameter int PARITY_ODD     = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [WORD_W-1:0]  wr_data,
   output logic               full,
   output logic               empty,
   output logic [FIFO_ADDR:0] level,
   output logic               busy,
   output logic               overflow,
   output logic               tx
);

   localparam int NCHAR = WORD_W / DATA_BITS;
   localparam int DEPTH = 1 << FIFO_ADDR;
   localparam int BW    = $clog2(BIT_CYCLES);
   localparam int CW    = (NCHAR > 1) ? $clog2(NCHAR) : 1;
   localparam int NW    = $clog2(DATA_BITS) + 1;

   localparam logic [BW-1:0]      BAUD_LAST  = BW'(BIT_CYCLES - 1);
   localparam logic [NW-1:0]      DATA_LAST  = NW'(DATA_BITS - 1);
   localparam logic [NW-1:0]      STOP_LAST  = NW'(STOP_BITS - 1);
   localparam logic [CW-1:0]      CHAR_LAST  = CW'(NCHAR - 1);
   localparam logic [FIFO_ADDR:0] LEVEL_FULL = (FIFO_ADDR + 1)'(DEPTH);

   if ((WORD_W % DATA_BITS) != 0 || DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
      $error("uart_tx_word: WORD_W must be a multiple of DATA_BITS, DATA_BITS in 5..9");
   end
   if (BIT_CYCLES < 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_timing
      $error("uart_tx_word: BIT_CYCLES must be >= 2 and STOP_BITS 1 or 2");
   end
   if (PARITY_ODD < 0 || PARITY_ODD > 1 || MSB_BYTE_FIRST < 0 || MSB_BYTE_FIRST > 1) begin : g_bad_flags
      $error("uart_tx_word: PARITY_ODD and MSB_BYTE_FIRST must be 0 or 1");
   end

`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   logic [WORD_W-1:0]    mem [DEPTH];
   logic [FIFO_ADDR-1:0] wr_ptr;
   logic [FIFO_ADDR-1:0] rd_ptr;
   logic [FIFO_ADDR:0]   level_nxt;
   logic                 push;
   logic                 pop;

   state_t               state;
   logic [BW-1:0]        baud_cnt;
   logic [NW-1:0]        bit_cnt;
   logic [CW-1:0]        char_cnt;
   logic [WORD_W-1:0]    word_sh;
   logic [DATA_BITS-1:0] char_sh;
   logic [DATA_BITS-1:0] char_sel;
   logic                 bit_end;
   logic                 stop_done;
`ifdef UART_PARITY_EN
   logic                 par_bit;
`endif

   assign push      = wr_en && !full;
   assign bit_end   = (baud_cnt == BAUD_LAST);
   assign stop_done = (state == S_STOP) && bit_end && (bit_cnt == STOP_LAST);
   // The next word is taken either from idle or straight out of the final stop bit.
   assign pop       = !empty && ((state == S_IDLE) || (stop_done && (char_cnt == '0)));
   assign char_sel  = (MSB_BYTE_FIRST != 0) ? word_sh[WORD_W-1 -: DATA_BITS]
                                            : word_sh[DATA_BITS-1:0];

   always_comb begin
      level_nxt = level;
      case ({push, pop})
         2'b10:   level_nxt = level + 1'b1;
         2'b01:   level_nxt = level - 1'b1;
         default: level_nxt = level;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         level <= level_nxt;
         full  <= (level_nxt == LEVEL_FULL);
         empty <= (level_nxt == '0);
         if (wr_en && full) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // Stage boundary: tx is registered from the current state, one cycle behind the FSM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         char_cnt <= '0;
         busy     <= 1'b0;
         tx       <= 1'b1;
      end else begin
         case (state)
            S_START:  tx <= 1'b0;
            S_DATA:   tx <= char_sh[0];
`ifdef UART_PARITY_EN
            S_PARITY: tx <= par_bit;
`endif
            default:  tx <= 1'b1;
         endcase

         baud_cnt <= ((state == S_IDLE) || bit_end) ? '0 : baud_cnt + 1'b1;

         case (state)
            S_IDLE: begin
               if (pop) begin
                  state    <= S_START;
                  char_cnt <= CHAR_LAST;
                  busy     <= 1'b1;
               end else begin
                  busy     <= 1'b0;
               end
            end
            S_START: begin
               if (bit_end) begin
                  state   <= S_DATA;
                  bit_cnt <= '0;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
`ifdef UART_PARITY_EN
                     state   <= S_PARITY;
`else
                     state   <= S_STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
               if (bit_end) state <= S_STOP;
            end
`endif
            S_STOP: begin
               if (bit_end) begin
                  if (bit_cnt != STOP_LAST) begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end else begin
                     bit_cnt <= '0;
                     if (char_cnt != '0) begin
                        char_cnt <= char_cnt - 1'b1;
                        state    <= S_START;
                     end else if (pop) begin
                        char_cnt <= CHAR_LAST;
                        state    <= S_START;
                     end else begin
                        state    <= S_IDLE;
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Word and character holding registers; validity is implied by the FSM state.
   always_ff @(posedge clk) begin
      if (pop) begin
         word_sh <= mem[rd_ptr];
      end else if ((state == S_START) && bit_end) begin
         char_sh <= char_sel;
         word_sh <= (MSB_BYTE_FIRST != 0) ? (word_sh << DATA_BITS) : (word_sh >> DATA_BITS);
`ifdef UART_PARITY_EN
         par_bit <= (^char_sel) ^ (PARITY_ODD != 0);
`endif
      end else if ((state == S_DATA) && bit_end) begin
         char_sh <= char_sh >> 1;
      end
   end

endmodule

// File: tb/tb_uart_tx_word.sv
// Scoreboard bench for uart_tx_word: two instances (LSB-first/1 stop, MSB-first/2 stop).
// Expected characters are queued on write and compared frame by frame as tx produces them.
module tb_uart_tx_word;

   localparam int BC0 = 4;
   localparam int BC1 = 3;
   localparam int FA0 = 4;
   localparam int FA1 = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en0, wr_en1;
   logic [31:0]   wr_data0, wr_data1;
   logic          full0, empty0, busy0, ovf0, tx0;
   logic          full1, empty1, busy1, ovf1, tx1;
   logic [FA0:0]  level0;
   logic [FA1:0]  level1;

   int            n_vec;
   int            n_err;
   logic [7:0]    exp_q0[$];
   logic [7:0]    exp_q1[$];

   always #5 clk = ~clk;

   uart_tx_word #(.BIT_CYCLES(BC0), .FIFO_ADDR(FA0)) u0 (
      .clk(clk), .reset(reset), .wr_en(wr_en0), .wr_data(wr_data0),
      .full(full0), .empty(empty0), .level(level0), .busy(busy0),
      .overflow(ovf0), .tx(tx0));

   uart_tx_word #(.BIT_CYCLES(BC1), .FIFO_ADDR(FA1), .STOP_BITS(2), .MSB_BYTE_FIRST(1)) u1 (
      .clk(clk), .reset(reset), .wr_en(wr_en1), .wr_data(wr_data1),
      .full(full1), .empty(empty1), .level(level1), .busy(busy1),
      .overflow(ovf1), .tx(tx1));

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic txv(input int sel);
      return (sel != 0) ? tx1 : tx0;
   endfunction

   function automatic int flen(input int sel);
      int l;
      l = 1 + 8 + ((sel != 0) ? 2 : 1);
`ifdef UART_PARITY_EN
      l++;
`endif
      return l;
   endfunction

   // Frame bits in transmission order, bit 0 = start bit.
   function automatic logic [15:0] frame_of(input int sel, input logic [7:0] c);
      logic [15:0] f;
      int          idx;
      f = '0;
      for (int i = 0; i < 8; i++) f[1+i] = c[i];
      idx = 9;
`ifdef UART_PARITY_EN
      f[idx] = ^c;
      idx++;
`endif
      for (int s = 0; s < ((sel != 0) ? 2 : 1); s++) f[idx+s] = 1'b1;
      return f;
   endfunction

   task automatic push_chars(input int sel, input logic [31:0] w);
      logic [7:0] c;
      for (int i = 0; i < 4; i++) begin
         c = (sel != 0) ? w[8*(3-i) +: 8] : w[8*i +: 8];
         if (sel != 0) exp_q1.push_back(c);
         else          exp_q0.push_back(c);
      end
   endtask

   task automatic write_word(input int sel, input logic [31:0] w, input bit accept);
      if (sel != 0) begin
         wr_en1 = 1'b1; wr_data1 = w;
      end else begin
         wr_en0 = 1'b1; wr_data0 = w;
      end
      if (accept) push_chars(sel, w);
      @(negedge clk);
      wr_en0 = 1'b0;
      wr_en1 = 1'b0;
   endtask

   task automatic wait_start(input int sel, output int cnt);
      cnt = 0;
      while (txv(sel) !== 1'b0 && cnt < 400) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   // Receives n frames; every frame after the first must start on the very next cycle.
   task automatic recv(input int sel, input int n, output int cycles,
                       output logic [15:0] first_f, output logic [15:0] last_f);
      int          len, bc, to;
      logic [7:0]  c;
      logic [15:0] e, o;
      logic        stable;
      bc = (sel != 0) ? BC1 : BC0;
      len = flen(sel);
      cycles = 0;
      first_f = '0;
      last_f = '0;
      for (int k = 0; k < n; k++) begin
         if (k != 0) begin
            n_vec++;
            if (txv(sel) !== 1'b0) begin
               n_err++;
               $display("FAIL gap u%0d frame %0d: tx=%b, required start bit 0", sel, k, txv(sel));
            end
         end
         wait_start(sel, to);
         if (to >= 400) begin
            n_vec++;
            n_err++;
            $display("FAIL start_timeout u%0d frame %0d: no start bit within 400 cycles", sel, k);
            return;
         end
         if (((sel != 0) ? exp_q1.size() : exp_q0.size()) == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_frame u%0d frame %0d: scoreboard empty", sel, k);
            return;
         end
         c = (sel != 0) ? exp_q1.pop_front() : exp_q0.pop_front();
         e = frame_of(sel, c);
         o = '0;
         stable = 1'b1;
         for (int b = 0; b < len; b++) begin
            o[b] = txv(sel);
            for (int j = 0; j < bc; j++) begin
               if (txv(sel) !== o[b]) stable = 1'b0;
               @(negedge clk);
               cycles++;
            end
         end
         n_vec++;
         if (!stable || o !== e) begin
            n_err++;
            $display("FAIL frame u%0d char %0d (0x%h): got bits %h stable=%b, required %h",
                     sel, k, c, o, stable, e);
         end
         if (k == 0) first_f = o;
         last_f = o;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_vec++;
      if ({tx0, full0, empty0, level0, busy0, ovf0} !== {1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_u0: tx/full/empty/level/busy/ovf = %b %b %b %0d %b %b, required 1 0 1 0 0 0",
                  tx0, full0, empty0, level0, busy0, ovf0);
      end
      n_vec++;
      if ({tx1, full1, empty1, level1, busy1, ovf1} !== {1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_u1: tx/full/empty/level/busy/ovf = %b %b %b %0d %b %b, required 1 0 1 0 0 0",
                  tx1, full1, empty1, level1, busy1, ovf1);
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({tx0, empty0, busy0} !== 3'b110) begin
         n_err++;
         $display("FAIL idle_after_reset: tx/empty/busy = %b%b%b, required 110", tx0, empty0, busy0);
      end
   endtask

   task automatic test_single_word();
      int          lat, cyc;
      logic [15:0] ff, lf;
      write_word(0, 32'h48656C6C, 1'b1);
      wait_start(0, lat);
      n_vec++;
      if (lat !== 2) begin
         n_err++;
         $display("FAIL latency: start bit %0d cycles after write, required 2", lat);
      end
      n_vec++;
      if ({empty0, level0, busy0} !== {1'b1, 5'd0, 1'b1}) begin
         n_err++;
         $display("FAIL after_pop: empty/level/busy = %b %0d %b, required 1 0 1", empty0, level0, busy0);
      end
      recv(0, 4, cyc, ff, lf);
      n_vec++;
      if (cyc !== 4 * flen(0) * BC0) begin
         n_err++;
         $display("FAIL word_duration: %0d cycles, required %0d", cyc, 4 * flen(0) * BC0);
      end
      n_vec++;
      if ({busy0, tx0, empty0} !== 3'b011) begin
         n_err++;
         $display("FAIL end_of_word: busy/tx/empty = %b%b%b, required 011", busy0, tx0, empty0);
      end
   endtask

   task automatic test_fill_overflow();
      int          cyc;
      logic [15:0] ff, lf;
      fork
         begin
            for (int i = 0; i < 17; i++) write_word(0, 32'hA0000000 + i * 32'h01010101, 1'b1);
            n_vec++;
            if ({full0, level0, ovf0} !== {1'b1, 5'd16, 1'b0}) begin
               n_err++;
               $display("FAIL fill: full/level/ovf = %b %0d %b, required 1 16 0", full0, level0, ovf0);
            end
            for (int i = 0; i < 2; i++) write_word(0, 32'hDEAD0000 + i, 1'b0);
            n_vec++;
            if ({full0, level0, ovf0} !== {1'b1, 5'd16, 1'b1}) begin
               n_err++;
               $display("FAIL overflow: full/level/ovf = %b %0d %b, required 1 16 1", full0, level0, ovf0);
            end
         end
         begin
            recv(0, 68, cyc, ff, lf);
         end
      join
      n_vec++;
      if ({ovf0, empty0, level0, busy0} !== {1'b1, 1'b1, 5'd0, 1'b0}) begin
         n_err++;
         $display("FAIL after_drain: ovf/empty/level/busy = %b %b %0d %b, required 1 1 0 0",
                  ovf0, empty0, level0, busy0);
      end
   endtask

   task automatic test_reset_mid_frame();
      int          to, cyc;
      logic [15:0] ff, lf;
      write_word(0, 32'h00000000, 1'b1);
      write_word(0, 32'h12345678, 1'b1);
      wait_start(0, to);
      repeat (54) @(negedge clk);
      n_vec++;
      if ({tx0, level0} !== {1'b0, 5'd1}) begin
         n_err++;
         $display("FAIL pre_reset: tx/level = %b %0d, required 0 1", tx0, level0);
      end
      reset = 1'b0;
      #1;
      n_vec++;
      if ({tx0, level0, ovf0, busy0, empty0} !== {1'b1, 5'd0, 1'b0, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL async_reset: tx/level/ovf/busy/empty = %b %0d %b %b %b, required 1 0 0 0 1",
                  tx0, level0, ovf0, busy0, empty0);
      end
      exp_q0.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      write_word(0, 32'hCAFEF00D, 1'b1);
      recv(0, 4, cyc, ff, lf);
      n_vec++;
      if (busy0 !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset_busy: busy=%b, required 0", busy0);
      end
   endtask

   task automatic test_msb_order();
      int          cyc;
      logic [15:0] ff, lf;
      write_word(1, 32'h11223344, 1'b1);
      write_word(1, 32'hAABBCCDD, 1'b1);
      recv(1, 8, cyc, ff, lf);
      n_vec++;
      if (ff[8:1] !== 8'h11 || lf[8:1] !== 8'hDD) begin
         n_err++;
         $display("FAIL msb_order: first char %h last char %h, required 11 and dd", ff[8:1], lf[8:1]);
      end
      n_vec++;
      if (cyc !== 8 * flen(1) * BC1) begin
         n_err++;
         $display("FAIL two_word_duration: %0d cycles, required %0d", cyc, 8 * flen(1) * BC1);
      end
   endtask

   task automatic test_stop_bits();
      int          cyc;
      logic [15:0] ff, lf;
      write_word(1, 32'h000000A5, 1'b1);
      recv(1, 4, cyc, ff, lf);
      n_vec++;
      if (cyc !== 4 * flen(1) * BC1) begin
         n_err++;
         $display("FAIL stop2_duration: %0d cycles, required %0d", cyc, 4 * flen(1) * BC1);
      end
`ifndef UART_PARITY_EN
      n_vec++;
      if (lf !== 16'b00000_11101001010) begin
         n_err++;
         $display("FAIL a5_frame: got bits %b, required 0,1,0,1,0,0,1,0,1,1,1", lf[10:0]);
      end
`endif
      n_vec++;
      if ({busy1, tx1} !== 2'b01) begin
         n_err++;
         $display("FAIL stop2_end: busy/tx = %b%b, required 01", busy1, tx1);
      end
   endtask

`ifdef UART_PARITY_EN
   task automatic test_parity();
      int          cyc;
      logic [15:0] ff, lf;
      write_word(0, 32'h00000007, 1'b1);
      recv(0, 4, cyc, ff, lf);
      n_vec++;
      if (ff[9] !== 1'b1 || lf[9] !== 1'b0) begin
         n_err++;
         $display("FAIL parity: bits %b/%b, required 1/0", ff[9], lf[9]);
      end
   endtask
`endif

   initial begin
      reset    = 1'b0;
      wr_en0   = 1'b0;
      wr_en1   = 1'b0;
      wr_data0 = '0;
      wr_data1 = '0;
      n_vec    = 0;
      n_err    = 0;
      test_reset();
      test_single_word();
      test_fill_overflow();
      test_reset_mid_frame();
      test_msb_order();
      test_stop_bits();
`ifdef UART_PARITY_EN
      test_parity();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
